regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's single-write, dual-read register file, for the planned pipelined core.
- Adds N read ports, M write ports, and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so issue logic can detect RAW hazards and stall.
- Sits between decode/issue and writeback; x0 stays hardwired to zero.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- NRP, 2, number of read ports.
- NWP, 2, number of write ports; a higher index has priority.
- BYPASS, 1, 1 forwards same-cycle write data to reads; 0 returns the old contents.
- AW is a localparam equal to $clog2(NREGS).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rs_en  input  NRP  read port p is used this cycle; it gates hazard reporting only.
- i_rs_addr  input  NRP*AW  read addresses; port p is at bits [p*AW +: AW].
- o_rs_data  output  NRP*XLEN  read data, combinational.
- o_rs_busy  output  NRP  the source register is pending and is not written this cycle.
- o_hazard  output  1  OR over p of i_rs_en[p] & o_rs_busy[p].
- i_wen  input  NWP  write enable per write port.
- i_wr_addr  input  NWP*AW  write addresses.
- i_wr_data  input  NWP*XLEN  write data.
- i_issue  input  1  an instruction with a destination is issued this cycle.
- i_issue_rd  input  AW  destination of the issued instruction.
- i_flush  input  1  clears every busy bit on the next edge.
- o_busy_vec  output  NREGS  scoreboard state, for debug and rvfi.

Behaviour:
- Reset (async, !i_rst_n):
  - All registers and busy bits are cleared to 0 immediately.
  - While reset is asserted, o_rs_data, o_rs_busy, o_hazard and o_busy_vec are all 0.
  - Asserting reset mid-operation discards any pending writes and issues.
- Register writes:
  - Take effect on posedge i_clk for each port with i_wen[w]=1 and addr != 0.
  - If two ports write the same address in one cycle, the highest-index port's data is stored. This is not an error.
- Register reads (combinational):
  - Address 0 always reads 0.
  - Otherwise, with BYPASS=1: if any write port targets the address this cycle, the highest-index matching port's i_wr_data is returned; else the stored value.
  - With BYPASS=0: always the stored value.
- Scoreboard, per register r != 0, next state:
  - If i_flush: 0.
  - Else if i_issue and i_issue_rd == r: 1. Issue wins over a same-cycle write, because the new producer supersedes the old one.
  - Else if any i_wen[w] with addr r: 0.
  - Else: hold.
- busy[0] is constant 0.
- i_issue with i_issue_rd == 0 has no effect.
- o_rs_busy[p]:
  - busy[addr] & ~(BYPASS & a write to addr this cycle).
  - Forced to 0 for addr 0.
- Latency:
  - A write is visible to reads in the same cycle with BYPASS=1, or in the next cycle with BYPASS=0.
  - A busy bit set by issue is visible from the next cycle.
- Write to a register that is not busy: accepted; busy stays 0. This covers non-scoreboarded writers.
- Flush together with a write in the same cycle: the data is written and the busy bit is cleared.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN, NREGS defaults, AW function.
  - A REG_ZERO constant.
  - A helper function that slices a flattened port bus.
- One sub-module, rf_bank: NREGS x XLEN storage with a priority-resolved multi-port write and its async reset.
- Scoreboard, bypass mux and hazard logic live in the top level.

Test Plan:
- Reset then read: read x5 and x0 -> 0 on both ports; o_busy_vec = 0; o_hazard = 0.
- Bypass: port0 writes x3 = 0xDEAD_BEEF_0000_0001 while rs0 = x3. BYPASS=1 -> rs0 data is 0xDEAD_BEEF_0000_0001 in the same cycle. BYPASS=0 -> old value 0, and the new value appears next cycle.
- Write priority: port0 writes x7 = 0x11 and port1 writes x7 = 0x22 in the same cycle -> x7 reads 0x22 afterwards.
- Scoreboard RAW:
  - Issue rd = x9, then next cycle rs_en0 = 1, rs0 = x9 -> o_hazard = 1.
  - Write x9 = 0x5 that cycle -> o_hazard = 0 and data reads 0x5 (BYPASS=1).
  - The cycle after -> o_busy_vec[9] = 0.
- Issue/write collision: x4 is busy; in one cycle, write x4 and issue rd = x4 -> x4 is busy the next cycle and holds the written data.
- x0 and flush:
  - Issue rd = x0 and write x0 = 0xFF -> x0 reads 0, busy[0] = 0.
  - Issue x1, x2, then i_flush -> o_busy_vec = 0.
  - Assert i_rst_n = 0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file definitions.
//   XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
//   REG_ZERO                     : index of the hardwired-zero register
//   addr_width()                 : address width for a given register count
//   slice_lo()                   : low bit of element idx in a flattened bus
package rv_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  // Flattened port buses pack element idx at [idx*w +: w].
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_bank.sv
// NREGS x XLEN register storage with NWP priority-resolved write ports.
//   i_clk, i_rst_n : clock, async active-low reset (clears all registers)
//   i_wen          : per-port write enable
//   i_wr_addr      : flattened write addresses, port w at [w*AW +: AW]
//   i_wr_data      : flattened write data, port w at [w*XLEN +: XLEN]
//   o_regs         : current contents of every register
module rf_bank
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NWP   = 2,
  localparam int AW   = addr_width(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NWP-1:0]      i_wen,
  input  logic [NWP*AW-1:0]   i_wr_addr,
  input  logic [NWP*XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0]     o_regs [NREGS]
);

  logic [XLEN-1:0] mem [NREGS];
  logic [AW-1:0]   wa;

  // Ports are applied in ascending order, so the highest-index writer of an
  // address is the last assignment and wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (i_wen[w] && (i_wr_addr[slice_lo(w, AW) +: AW] != AW'(REG_ZERO)))
          mem[i_wr_addr[slice_lo(w, AW) +: AW]] <= i_wr_data[slice_lo(w, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) o_regs[r] = mem[r];
    o_regs[REG_ZERO] = '0;
  end

  // Unused helper to keep wa referenced-free; no logic depends on it.
  assign wa = '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a busy scoreboard
// for RAW hazard detection at issue.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_rs_en/i_rs_addr  : read port enables (hazard gating) and addresses
//   o_rs_data          : combinational read data per port
//   o_rs_busy/o_hazard : per-port pending source, and OR of enabled ones
//   i_wen/i_wr_addr/i_wr_data : writeback ports, higher index has priority
//   i_issue/i_issue_rd : mark a destination register as pending
//   i_flush            : clear the whole scoreboard on the next edge
//   o_busy_vec         : scoreboard state
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRP-1:0]      i_rs_en,
  input  logic [NRP*AW-1:0]   i_rs_addr,
  output logic [NRP*XLEN-1:0] o_rs_data,
  output logic [NRP-1:0]      o_rs_busy,
  output logic                o_hazard,
  input  logic [NWP-1:0]      i_wen,
  input  logic [NWP*AW-1:0]   i_wr_addr,
  input  logic [NWP*XLEN-1:0] i_wr_data,
  input  logic                i_issue,
  input  logic [AW-1:0]       i_issue_rd,
  input  logic                i_flush,
  output logic [NREGS-1:0]    o_busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    wa;
  logic             hit;
  logic [XLEN-1:0]  byp;
  logic [XLEN-1:0]  val;

  rf_bank #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWP   (NWP)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wen     (i_wen),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .o_regs    (regs)
  );

  // Read path: highest-index matching writer forwards when bypass is enabled.
  // Forwarded write data would otherwise leak out during reset, so data is
  // gated by i_rst_n.
  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    ra  = '0;
    hit = 1'b0;
    byp = '0;
    val = '0;
    for (int p = 0; p < NRP; p++) begin
      ra  = i_rs_addr[slice_lo(p, AW) +: AW];
      hit = 1'b0;
      byp = '0;
      for (int w = 0; w < NWP; w++) begin
        if (i_wen[w] && (i_wr_addr[slice_lo(w, AW) +: AW] == ra)) begin
          hit = 1'b1;
          byp = i_wr_data[slice_lo(w, XLEN) +: XLEN];
        end
      end
      val = (BYPASS != 0 && hit) ? byp : regs[ra];
      if (ra == AW'(REG_ZERO) || !i_rst_n) val = '0;
      o_rs_data[slice_lo(p, XLEN) +: XLEN] = val;
      o_rs_busy[p] = busy_q[ra] && !(BYPASS != 0 && hit) && (ra != AW'(REG_ZERO));
    end
  end

  assign o_hazard = |(i_rs_en & o_rs_busy);

  // Priority low to high: write clears, issue sets, flush clears all.
  always_comb begin
    busy_d = busy_q;
    wa     = '0;
    for (int w = 0; w < NWP; w++) begin
      wa = i_wr_addr[slice_lo(w, AW) +: AW];
      if (i_wen[w]) busy_d[wa] = 1'b0;
    end
    if (i_issue) busy_d[i_issue_rd] = 1'b1;
    if (i_flush) busy_d = '0;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [1:0] rs_en = '0;
  logic [AW-1:0] rs0 = '0, rs1 = '0, wa0 = '0, wa1 = '0, issue_rd = '0;
  logic [63:0] wd0 = '0, wd1 = '0;
  logic [1:0] wen = '0;
  logic issue = 1'b0, flush = 1'b0;

  logic [2*AW-1:0] rs_addr, wr_addr;
  logic [2*XLEN-1:0] wr_data;
  assign rs_addr = {rs1, rs0};
  assign wr_addr = {wa1, wa0};
  assign wr_data = {wd1, wd0};

  logic [2*XLEN-1:0] rs_data, nb_rs_data;
  logic [1:0] rs_busy, nb_rs_busy;
  logic hazard, nb_hazard;
  logic [NREGS-1:0] busy_vec, nb_busy_vec;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_en(rs_en), .i_rs_addr(rs_addr),
    .o_rs_data(rs_data), .o_rs_busy(rs_busy), .o_hazard(hazard),
    .i_wen(wen), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue(issue), .i_issue_rd(issue_rd), .i_flush(flush), .o_busy_vec(busy_vec)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_en(rs_en), .i_rs_addr(rs_addr),
    .o_rs_data(nb_rs_data), .o_rs_busy(nb_rs_busy), .o_hazard(nb_hazard),
    .i_wen(wen), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue(issue), .i_issue_rd(issue_rd), .i_flush(flush), .o_busy_vec(nb_busy_vec)
  );

  always #5 i_clk = ~i_clk;

  localparam int S_D0 = 0, S_D1 = 1, S_BV = 2, S_HZ = 3, S_NB_D0 = 4, S_NB_HZ = 5,
                 S_RSB = 6, S_NB_BV = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  bit done = 1'b0;

  task automatic expect_val(input string name, input int sig, input logic [63:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] actual(input int sig);
    case (sig)
      S_D0:    return rs_data[63:0];
      S_D1:    return rs_data[127:64];
      S_BV:    return 64'(busy_vec);
      S_HZ:    return 64'(hazard);
      S_NB_D0: return nb_rs_data[63:0];
      S_NB_HZ: return 64'(nb_hazard);
      S_RSB:   return 64'(rs_busy);
      S_NB_BV: return 64'(nb_busy_vec);
      default: return 64'hX;
    endcase
  endfunction

  // Monitor: drains every expectation queued since the last check, sampling
  // the DUT outputs on the falling edge.
  always @(negedge i_clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = actual(e.sig);
      n_tests++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    wen = '0; issue = 1'b0; flush = 1'b0; rs_en = '0;
  endtask

  initial begin
    // Reset state, with a write present to prove bypass is gated.
    rs0 = 5; rs1 = 0; wen = 2'b01; wa0 = 5; wd0 = 64'h1234;
    tick();
    expect_val("rst_rd_x5", S_D0, 64'h0);
    expect_val("rst_rd_x0", S_D1, 64'h0);
    expect_val("rst_busy_vec", S_BV, 64'h0);
    expect_val("rst_hazard", S_HZ, 64'h0);
    tick();
    idle();
    i_rst_n = 1'b1;

    // Bypass of a same-cycle write vs. stored value.
    tick();
    wen = 2'b01; wa0 = 3; wd0 = 64'hDEAD_BEEF_0000_0001; rs0 = 3;
    expect_val("byp_same_cycle", S_D0, 64'hDEAD_BEEF_0000_0001);
    expect_val("nobyp_old_value", S_NB_D0, 64'h0);
    tick();
    idle();
    expect_val("byp_next_cycle", S_D0, 64'hDEAD_BEEF_0000_0001);
    expect_val("nobyp_next_cycle", S_NB_D0, 64'hDEAD_BEEF_0000_0001);

    // Write port priority.
    tick();
    wen = 2'b11; wa0 = 7; wd0 = 64'h11; wa1 = 7; wd1 = 64'h22; rs0 = 7;
    expect_val("prio_bypass", S_D0, 64'h22);
    tick();
    idle();
    expect_val("prio_stored", S_D0, 64'h22);
    expect_val("prio_stored_nb", S_NB_D0, 64'h22);

    // RAW hazard on x9.
    tick();
    issue = 1'b1; issue_rd = 9; rs_en = 2'b01; rs0 = 9;
    expect_val("issue_not_yet_busy", S_HZ, 64'h0);
    tick();
    idle(); rs_en = 2'b01; rs0 = 9;
    expect_val("raw_hazard", S_HZ, 64'h1);
    expect_val("raw_busy_vec", S_BV, 64'h200);
    expect_val("raw_rs_busy", S_RSB, 64'h1);
    tick();
    rs_en = 2'b01; rs0 = 9; wen = 2'b01; wa0 = 9; wd0 = 64'h5;
    expect_val("wb_clears_hazard", S_HZ, 64'h0);
    expect_val("wb_bypass_data", S_D0, 64'h5);
    expect_val("wb_nobyp_hazard", S_NB_HZ, 64'h1);
    expect_val("wb_nobyp_data", S_NB_D0, 64'h0);
    tick();
    idle(); rs0 = 9;
    expect_val("wb_busy_cleared", S_BV, 64'h0);
    expect_val("wb_stored", S_D0, 64'h5);

    // Issue and write to the same register in one cycle.
    tick();
    issue = 1'b1; issue_rd = 4;
    tick();
    idle(); wen = 2'b10; wa1 = 4; wd1 = 64'h44; issue = 1'b1; issue_rd = 4;
    expect_val("coll_busy_before", S_BV, 64'h10);
    tick();
    idle(); rs1 = 4; rs_en = 2'b10;
    expect_val("coll_busy_after", S_BV, 64'h10);
    expect_val("coll_data", S_D1, 64'h44);
    expect_val("coll_hazard", S_HZ, 64'h1);

    // x0 is never written or marked busy.
    tick();
    idle(); issue = 1'b1; issue_rd = 0; wen = 2'b01; wa0 = 0; wd0 = 64'hFF; rs0 = 0; rs1 = 0;
    expect_val("x0_bypass_rd0", S_D0, 64'h0);
    expect_val("x0_bypass_rd1", S_D1, 64'h0);
    tick();
    idle();
    expect_val("x0_stored", S_D0, 64'h0);
    expect_val("x0_not_busy", S_BV, 64'h10);

    // Flush with a concurrent write.
    issue = 1'b1; issue_rd = 1;
    tick();
    issue = 1'b1; issue_rd = 2;
    expect_val("flush_pre_busy", S_BV, 64'h12);
    tick();
    idle(); flush = 1'b1; wen = 2'b01; wa0 = 5; wd0 = 64'hAB;
    expect_val("flush_pre_busy2", S_BV, 64'h16);
    tick();
    idle(); rs0 = 5;
    expect_val("flush_busy_vec", S_BV, 64'h0);
    expect_val("flush_nb_busy_vec", S_NB_BV, 64'h0);
    expect_val("flush_write_data", S_D0, 64'hAB);

    // Asynchronous reset mid-stream.
    issue = 1'b1; issue_rd = 6;
    tick();
    idle(); wen = 2'b01; wa0 = 3; wd0 = 64'h77; rs0 = 3; rs1 = 7; rs_en = 2'b11;
    issue = 1'b1; issue_rd = 8;
    #1;
    i_rst_n = 1'b0;
    expect_val("arst_data0", S_D0, 64'h0);
    expect_val("arst_data1", S_D1, 64'h0);
    expect_val("arst_busy_vec", S_BV, 64'h0);
    expect_val("arst_hazard", S_HZ, 64'h0);
    expect_val("arst_rs_busy", S_RSB, 64'h0);
    tick();
    idle(); rs0 = 3; rs1 = 7;
    i_rst_n = 1'b1;
    tick();
    expect_val("post_rst_x3", S_D0, 64'h0);
    expect_val("post_rst_x7", S_D1, 64'h0);
    expect_val("post_rst_busy", S_BV, 64'h0);

    tick();
    tick();
    done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (done);
        @(negedge i_clk);
        n_tests++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
      end
      begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: got no completion expected completion");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
